// File: rtl/speed_switch_sequencer.sv
// KEY1 (CGB speed switch) register, CPU tick-enable divider and the
// STOP-triggered halt/drain/settle/switch sequence.
module speed_switch_sequencer #(
    parameter logic [15:0] P_KEY1_ADDR     = 16'hFF4D,
    parameter int unsigned P_DIV_NORMAL    = 8,
    parameter int unsigned P_DIV_DOUBLE    = 4,
    parameter int unsigned P_SETTLE_CYCLES = 255,
    parameter int unsigned P_DRAIN_TIMEOUT = 1023
) (
    input  logic        I_CLK33MHZ,
    input  logic        I_SYNC_RESET,
    input  logic [15:0] I_IOREG_ADDR,
    input  logic [7:0]  I_IOREG_WDATA,
    input  logic        I_IOREG_WE_L,
    input  logic        I_IOREG_RE_L,
    output logic [7:0]  O_IOREG_RDATA,
    output logic        O_IOREG_RDATA_EN,
    input  logic        I_STOP_REQ,
    input  logic        I_MEM_BUSY,
    output logic        O_CPU_CE,
    output logic        O_CPU_HALT,
    output logic        O_IS_IN_DOUBLE_SPEEDMODE,
    output logic        O_DISABLE_CONTROLLER,
    output logic        O_SWITCH_DONE,
    output logic        O_DRAIN_TIMEOUT,
    output logic [1:0]  O_STATE
);

    localparam logic [7:0]  DIV_N_MAX = 8'(P_DIV_NORMAL - 1);
    localparam logic [7:0]  DIV_D_MAX = 8'(P_DIV_DOUBLE - 1);
    localparam logic [15:0] SETTLE_LD = 16'(P_SETTLE_CYCLES);
    localparam logic [16:0] DRAIN_LIM = 17'(P_DRAIN_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRAIN  = 2'd1,
        S_SETTLE = 2'd2,
        S_SWITCH = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic        speed_q, speed_d;
    logic        prepare_q, prepare_d;
    logic        timeout_q, timeout_d;
    logic [7:0]  div_q, div_d;
    logic [15:0] drain_q, drain_d;
    logic [15:0] settle_q, settle_d;

    logic       key1_hit, key1_wr, halt;
    logic [7:0] div_max;
    logic       unused_wdata;

    assign key1_hit     = (I_IOREG_ADDR == P_KEY1_ADDR);
    assign key1_wr      = ~I_IOREG_WE_L & key1_hit;
    assign div_max      = speed_q ? DIV_D_MAX : DIV_N_MAX;
    assign unused_wdata = ^I_IOREG_WDATA[7:1];

    always_ff @(posedge I_CLK33MHZ) begin
        if (I_SYNC_RESET) begin
            state_q   <= S_IDLE;
            speed_q   <= 1'b0;
            prepare_q <= 1'b0;
            timeout_q <= 1'b0;
            div_q     <= '0;
            drain_q   <= '0;
            settle_q  <= '0;
        end else begin
            state_q   <= state_d;
            speed_q   <= speed_d;
            prepare_q <= prepare_d;
            timeout_q <= timeout_d;
            div_q     <= div_d;
            drain_q   <= drain_d;
            settle_q  <= settle_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        speed_d       = speed_q;
        prepare_d     = prepare_q;
        timeout_d     = timeout_q;
        div_d         = '0;
        drain_d       = drain_q;
        settle_d      = settle_q;
        halt          = 1'b1;
        O_SWITCH_DONE = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                halt  = 1'b0;
                div_d = (div_q >= div_max) ? 8'd0 : div_q + 8'd1;
                if (key1_wr) prepare_d = I_IOREG_WDATA[0];
                // registered prepare decides, so a same-cycle KEY1 write cannot arm this STOP
                if (I_STOP_REQ && prepare_q) begin
                    state_d = S_DRAIN;
                    drain_d = '0;
                end
            end
            S_DRAIN: begin
                drain_d = drain_q + 16'd1;
                if (!I_MEM_BUSY) begin
                    state_d  = S_SETTLE;
                    settle_d = SETTLE_LD;
                end else if (({1'b0, drain_q} + 17'd1) >= DRAIN_LIM) begin
                    state_d   = S_SETTLE;
                    settle_d  = SETTLE_LD;
                    timeout_d = 1'b1;
                end
            end
            S_SETTLE: begin
                if (settle_q == 16'd0) state_d = S_SWITCH;
                else                   settle_d = settle_q - 16'd1;
            end
            S_SWITCH: begin
                O_SWITCH_DONE = 1'b1;
                speed_d       = ~speed_q;
                prepare_d     = 1'b0;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign O_CPU_CE                 = (state_q == S_IDLE) && (div_q == div_max);
    assign O_CPU_HALT               = halt;
    assign O_DISABLE_CONTROLLER     = halt;
    assign O_IS_IN_DOUBLE_SPEEDMODE = speed_q;
    assign O_DRAIN_TIMEOUT          = timeout_q;
    assign O_STATE                  = state_q;
    assign O_IOREG_RDATA_EN         = ~I_IOREG_RE_L & key1_hit;
    assign O_IOREG_RDATA            = O_IOREG_RDATA_EN ? {speed_q, 6'b111111, prepare_q} : 8'h00;

endmodule

// File: doc/speed_switch_sequencer.md
Name: speed_switch_sequencer

Overview:
Owns the GBC KEY1 register (0xFF4D) and the CPU tick rate. It generates a single-cycle CPU clock-enable from the 33 MHz base clock at the normal or double-speed rate. When the CPU executes STOP with KEY1.prepare set, it sequences the armed speed switch: halt the CPU, drain memory, settle, flip the speed, then resume. It sits between the CPU core, the memory router and the I/O register bus.

Parameters:
P_KEY1_ADDR, 16'hFF4D, I/O address of KEY1.
P_DIV_NORMAL, 8, base clocks per CPU tick in normal speed (range 2..255).
P_DIV_DOUBLE, 4, base clocks per CPU tick in double speed (range 2..255).
P_SETTLE_CYCLES, 255, base clocks held in SETTLE (16-bit).
P_DRAIN_TIMEOUT, 1023, maximum base clocks spent waiting in DRAIN (16-bit).

Ports:
I_CLK33MHZ  in  1  base clock; the only clock.
I_SYNC_RESET  in  1  synchronous, active-high reset.
I_IOREG_ADDR  in  16  I/O bus address.
I_IOREG_WDATA  in  8  I/O write data.
I_IOREG_WE_L  in  1  write strobe, active low.
I_IOREG_RE_L  in  1  read strobe, active low.
O_IOREG_RDATA  out  8  KEY1 read value.
O_IOREG_RDATA_EN  out  1  drive enable for the shared data bus.
I_STOP_REQ  in  1  CPU executed STOP; one-base-clock pulse.
I_MEM_BUSY  in  1  memory router has a transaction in flight.
O_CPU_CE  out  1  CPU tick enable; one base clock wide.
O_CPU_HALT  out  1  CPU frozen.
O_IS_IN_DOUBLE_SPEEDMODE  out  1  current speed.
O_DISABLE_CONTROLLER  out  1  joypad/controller block disabled during the switch.
O_SWITCH_DONE  out  1  one-cycle pulse when the speed flips.
O_DRAIN_TIMEOUT  out  1  sticky flag: drain exited on timeout; cleared only by reset.
O_STATE  out  2  FSM state, for debug.

Behaviour:
- Reset values: all outputs 0; internal state is speed=0, prepare=0, state=IDLE, divider=0, counters=0. A reset asserted mid-switch aborts the sequence; the speed does not flip.
- KEY1 write:
  - When ~WE_L and ADDR==P_KEY1_ADDR are sampled on a clock edge: prepare <= WDATA[0].
  - Writes are accepted only in IDLE and ignored in every other state.
  - A strobe held for several cycles rewrites the same value, which is harmless.
- KEY1 read (combinational):
  - RDATA_EN = ~RE_L & (ADDR==P_KEY1_ADDR).
  - RDATA = {speed, 6'b111111, prepare} whenever RDATA_EN is high, else 8'h00.
- Divider:
  - D = speed ? P_DIV_DOUBLE : P_DIV_NORMAL.
  - 8-bit counter increments each clock in IDLE and wraps to 0 after D-1. It is held at 0 in all other states.
  - O_CPU_CE = (state==IDLE) & (counter==D-1), combinational.
- FSM (O_STATE encoding): IDLE=0, DRAIN=1, SETTLE=2, SWITCH=3.
  - IDLE: HALT=0, DISABLE=0. If I_STOP_REQ and the registered prepare==1, go to DRAIN and clear the drain counter. A STOP with prepare==0 is ignored here. If a KEY1 write and a STOP land in the same cycle, the pre-write prepare value decides.
  - DRAIN: HALT=1, DISABLE=1, drain counter increments each cycle.
    - If I_MEM_BUSY==0, go to SETTLE and load settle=P_SETTLE_CYCLES.
    - Otherwise, if the drain counter reaches P_DRAIN_TIMEOUT, go to SETTLE, load settle, and set O_DRAIN_TIMEOUT.
  - SETTLE: HALT=1, DISABLE=1. Settle decrements each cycle; when settle==0, go to SWITCH. SETTLE lasts P_SETTLE_CYCLES+1 cycles.
  - SWITCH (one cycle): HALT=1, DISABLE=1, O_SWITCH_DONE=1. Registered effects: speed <= ~speed, prepare <= 0, then go to IDLE.
- Latency: STOP sampled at cycle t with memory idle gives the following sequence.
  - DRAIN at t+1.
  - SETTLE spans t+2..t+2+P_SETTLE_CYCLES.
  - SWITCH at t+3+P_SETTLE_CYCLES.
  - IDLE at t+4+P_SETTLE_CYCLES.
  - First CE at the D_new-th IDLE cycle.
- I_STOP_REQ outside IDLE is ignored. I_MEM_BUSY is ignored outside DRAIN.

Test Plan:
- Reset, then read 0xFF4D with RE_L=0 -> RDATA=8'h7E, RDATA_EN=1. O_CPU_CE pulses once every 8 clocks.
- Write 0x01 to 0xFF4D, then read back -> 8'h7F. Pulse STOP with MEM_BUSY=0 -> HALT/DISABLE rise next cycle, SWITCH_DONE at t+258, O_IS_IN_DOUBLE_SPEEDMODE=1, read gives 8'hFE, CE period becomes 4.
- Same sequence but MEM_BUSY=1 for 20 cycles after STOP -> SETTLE entered on the first cycle MEM_BUSY is low. Switch is delayed by 20 cycles; DRAIN_TIMEOUT stays 0.
- MEM_BUSY stuck at 1 -> exit DRAIN after 1023 cycles, DRAIN_TIMEOUT=1, switch still completes.
- STOP with prepare=0 -> no state change, CE continues. A KEY1 write of 0x01 in the same cycle as STOP -> still no switch; prepare reads 1 afterwards.
- Assert I_SYNC_RESET mid-SETTLE -> next cycle state=IDLE, speed=0, prepare=0, HALT=0, SWITCH_DONE never pulses.
